// File: rtl/onehot_decoder_pipe.sv
// Registered valid/ready N-to-2^N one-hot decoder with a two-entry skid buffer.
// Define ONEHOT_DEC_STATS_EN to add the stats_clr / null_cnt null-transaction counter.
module onehot_decoder_pipe #(
    parameter  int IN_W  = 2,
`ifdef ONEHOT_DEC_STATS_EN
    parameter  int CNT_W = 8,
`endif
    localparam int OUT_W = 1 << IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
`ifdef ONEHOT_DEC_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] null_cnt,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [OUT_W-1:0]  r_main;
    logic [OUT_W-1:0]  r_skid;
    logic [OUT_W-1:0]  w_entry;
    logic              w_accept;
    logic              w_pop;

    // A null transaction (in_en=0) still occupies a slot, carrying an all-zero vector.
    assign w_entry  = in_en ? (OUT_W'(1) << in_code) : '0;

    // Handshake flags depend only on state, so out_ready never reaches in_ready.
    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_onehot = out_valid ? r_main : '0;

    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_entry;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && !w_pop) begin
                        r_skid  <= w_entry;
                        r_state <= FULL;
                    end else if (w_pop && !w_accept) begin
                        r_state <= EMPTY;
                    end else if (w_accept && w_pop) begin
                        r_main  <= w_entry;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef ONEHOT_DEC_STATS_EN
    logic [CNT_W-1:0] r_null_cnt;

    // Clear has priority; the count saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_null_cnt <= '0;
        end else if (stats_clr) begin
            r_null_cnt <= '0;
        end else if (w_accept && !in_en && (r_null_cnt != {CNT_W{1'b1}})) begin
            r_null_cnt <= r_null_cnt + 1'b1;
        end
    end

    assign null_cnt = r_null_cnt;
`endif

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe: directed vector table, corner sequences, random scoreboard.
`timescale 1ns/1ps
module tb_onehot_decoder_pipe;

    localparam int IN_W  = 2;
    localparam int OUT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
`ifdef ONEHOT_DEC_STATS_EN
    logic             stats_clr;
    logic [7:0]       null_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onehot_decoder_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
`ifdef ONEHOT_DEC_STATS_EN
        .stats_clr  (stats_clr),
        .null_cnt   (null_cnt),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot)
    );

    typedef struct {
        logic [IN_W-1:0]  code;
        logic             en;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IN_W-1:0] code, input logic en);
        in_valid = 1'b1;
        in_code  = code;
        in_en    = en;
        step();
        in_valid = 1'b0;
    endtask

    logic [OUT_W-1:0] q[$];
    logic [OUT_W-1:0] exp_v;
    logic [OUT_W-1:0] prev_val;
    logic             prev_stall;
    logic             have_item;
    logic [IN_W-1:0]  item_code;
    logic             item_en;
    int               sent, rcvd, cycles;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_en     = 1'b0;
        out_ready = 1'b0;
`ifdef ONEHOT_DEC_STATS_EN
        stats_clr = 1'b0;
`endif
        vecs[0] = '{code: 2'd0, en: 1'b1, exp: 4'b0001};
        vecs[1] = '{code: 2'd1, en: 1'b1, exp: 4'b0010};
        vecs[2] = '{code: 2'd2, en: 1'b1, exp: 4'b0100};
        vecs[3] = '{code: 2'd3, en: 1'b1, exp: 4'b1000};
        vecs[4] = '{code: 2'd2, en: 1'b0, exp: 4'b0000};

        // Reset state, with in_valid held high across a reset edge.
        repeat (2) step();
        in_valid = 1'b1;
        in_en    = 1'b1;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_onehot", out_onehot, 0);
        check("rst_in_ready", in_ready, 1);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        check("idle_out_valid", out_valid, 0);

        // Streaming table with out_ready held high: one output per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = vecs[i].code;
            in_en    = vecs[i].en;
            check($sformatf("stream_in_ready[%0d]", i), in_ready, 1);
            step();
            check($sformatf("stream_valid[%0d]", i), out_valid, 1);
            check($sformatf("stream_onehot[%0d]", i), out_onehot, vecs[i].exp);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);
        check("drain_onehot", out_onehot, 0);

        // Back-pressure fills the skid, then drains in order.
        out_ready = 1'b0;
        push(2'd2, 1'b1);
        push(2'd3, 1'b1);
        check("full_in_ready", in_ready, 0);
        check("full_onehot", out_onehot, 4'b0100);
        step();
        check("full_hold", out_onehot, 4'b0100);
        out_ready = 1'b1;
        step();
        check("pop1_onehot", out_onehot, 4'b1000);
        check("pop1_in_ready", in_ready, 1);
        step();
        check("pop2_empty", out_valid, 0);

        // Simultaneous accept and pop while holding one entry.
        out_ready = 1'b0;
        push(2'd1, 1'b1);
        check("one_onehot", out_onehot, 4'b0010);
        out_ready = 1'b1;
        push(2'd3, 1'b1);
        check("swap_valid", out_valid, 1);
        check("swap_onehot", out_onehot, 4'b1000);
        check("swap_in_ready", in_ready, 1);
        step();
        check("swap_drained", out_valid, 0);

`ifdef ONEHOT_DEC_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("cnt_cleared", null_cnt, 0);
        push(2'd2, 1'b0);
        check("cnt_one", null_cnt, 1);
        check("null_onehot", out_onehot, 0);
        check("null_valid", out_valid, 1);
        in_valid = 1'b1;
        in_en    = 1'b0;
        repeat (300) step();
        in_valid = 1'b0;
        check("cnt_sat", null_cnt, 255);
        in_valid  = 1'b1;
        stats_clr = 1'b1;
        step();
        in_valid  = 1'b0;
        stats_clr = 1'b0;
        check("cnt_clr_wins", null_cnt, 0);
        step();
`endif

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        push(2'd0, 1'b0);
        push(2'd3, 1'b1);
        check("pre_rst_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_onehot", out_onehot, 0);
        check("arst_in_ready", in_ready, 1);
`ifdef ONEHOT_DEC_STATS_EN
        check("arst_cnt", null_cnt, 0);
`endif
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        push(2'd1, 1'b1);
        check("post_rst_onehot", out_onehot, 4'b0010);
        step();
        check("post_rst_empty", out_valid, 0);

        // Random handshake with scoreboard and stall-stability check.
        sent = 0; rcvd = 0; cycles = 0;
        have_item = 1'b0; prev_stall = 1'b0; prev_val = '0;
        item_code = '0; item_en = 1'b0;
        while (rcvd < 1000 && cycles < 20000) begin
            if (prev_stall) begin
                if (out_onehot !== prev_val) check("stall_stable", out_onehot, prev_val);
            end
            if (!have_item && sent < 1000) begin
                item_code = IN_W'($urandom_range(0, 3));
                item_en   = ($urandom_range(0, 3) != 0);
                have_item = 1'b1;
            end
            in_valid  = have_item && ($urandom_range(0, 1) == 1);
            in_code   = item_code;
            in_en     = item_en;
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_v = q.pop_front();
                    if (out_onehot !== exp_v) check("sb_data", out_onehot, exp_v);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(item_en ? (OUT_W'(1) << item_code) : '0);
                have_item = 1'b0;
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_val   = out_onehot;
            step();
            cycles++;
        end
        in_valid = 1'b0;
        check("sb_count", rcvd, 1000);
        check("sb_leftover", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_pipe.md
Name: onehot_decoder_pipe

Overview:
- Registered, flow-controlled N-to-2^N decoder.
- Receive-side counterpart of the team's 4-to-2 priority-free encoder: takes an encoded index plus encoder-valid flag and regenerates the one-hot vector.
- Two-entry skid buffer decouples upstream from downstream back-pressure; inputs and outputs both use a valid/ready handshake.
- Sits between the encoder output and any one-hot consumer (mux select, request lines).

Parameters:
- IN_W, 2, width of the encoded index.
- OUT_W, 1<<IN_W, one-hot width; derived, must not be overridden.
- CNT_W, 8, width of the null-transaction counter (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream transaction present.
- in_ready  output  1  decoder can accept this cycle.
- in_code  input  IN_W  encoded index.
- in_en  input  1  encoder valid flag; 0 marks a null transaction.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  downstream accepts.
- out_onehot  output  OUT_W  decoded vector.

Behaviour:
- Accept = in_valid && in_ready at the rising edge. Pop = out_valid && out_ready at the rising edge.
- Stored entry is (1 << in_code) when in_en=1, and all-zero when in_en=0. A null entry is still a transaction: it occupies a slot and is presented with out_valid=1.
- FSM states: EMPTY, ONE, FULL. Outputs are a pure function of state: in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: accept -> ONE; main register loads.
- ONE:
  - accept && !pop -> FULL; skid register loads.
  - pop && !accept -> EMPTY.
  - accept && pop -> ONE; main register reloads with new entry.
  - neither -> ONE; hold.
- FULL: no accept possible. pop -> ONE; main register takes skid. No pop -> hold.
- Latency: entry accepted at edge k is visible on out_onehot after edge k (one cycle).
- Throughput: one transaction per cycle while out_ready=1.
- No combinational path from out_ready to in_ready.
- out_onehot is driven to 0 whenever out_valid=0.
- out_onehot is held stable while out_valid && !out_ready.
- Order is strictly FIFO; no entry is dropped or duplicated.
- Reset (rst_n low, any cycle, including mid-transfer):
  - state EMPTY, out_valid 0, out_onehot 0, in_ready 1.
  - Both entries are discarded.
  - Accept is ignored while rst_n=0.
  - First accept is possible on the first edge after release.
- in_code values are always in range because OUT_W = 2^IN_W.

Optional Feature:
- Macro ONEHOT_DEC_STATS_EN.
- When defined, adds ports:
  - stats_clr  input  1  synchronous clear.
  - null_cnt  output  CNT_W  count of accepted transactions with in_en=0.
- null_cnt increments on each accept with in_en=0, saturating at 2^CNT_W-1. It resets to 0 on rst_n low.
- stats_clr=1 clears null_cnt to 0; clear wins over a simultaneous increment.
- When not defined, neither port exists and no counter logic is generated. Handshake behaviour is identical in both builds.

Test Plan:
- Reset, then stream codes 0,1,2,3 with in_en=1 and out_ready=1 held high -> out_onehot 0001,0010,0100,1000 on consecutive cycles, each one cycle after its accept; in_ready stays 1.
- out_ready=0 while sending codes 2 then 3 -> after 2 accepts state is FULL and in_ready=0; out_onehot holds 0100. Raise out_ready -> 0100 then 1000 delivered in order, and in_ready returns to 1 after the first pop.
- Single-cycle simultaneous accept and pop in ONE (queued code 1, push code 3) -> state remains ONE; next cycle out_onehot=1000 with nothing lost.
- Transaction with in_en=0, in_code=2 -> out_valid=1 with out_onehot=0000. With ONEHOT_DEC_STATS_EN, null_cnt goes 0->1. Drive 300 such transactions -> null_cnt saturates at 255. stats_clr asserted on the same cycle as a null accept -> null_cnt=0.
- Assert rst_n low asynchronously while FULL -> out_valid, out_onehot and null_cnt go to 0 immediately. After release, code 1 is accepted and appears as 0010.
- Random in_valid/out_ready (50%) over 1000 codes with a scoreboard -> output sequence equals input decode sequence, and out_onehot never changes while stalled.
